alu_demo_sequencer: RTL and testbench

//  Control front end for the button-driven ALU demo datapath: debounces the board buttons and

---
 rtl/alu_demo_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_demo_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_demo_sequencer.sv
// Button front end for the ALU demo: synchronises and debounces four buttons, then
// drives operands/option either from the buttons (MANUAL) or from a timed 16-step sweep (AUTO).
module alu_demo_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd12000,
  parameter logic [23:0] DWELL_CYCLES    = 24'd6000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_next,
  input  logic       btn_mode,
  output logic       operand_a,
  output logic       operand_b,
  output logic [1:0] option,
  output logic       auto_active,
  output logic       step_strobe,
  output logic       sweep_done
);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_RUN  = 2'd1,
    ST_AUTO_DONE = 2'd2
  } state_t;

  // Button lanes: [0]=a, [1]=b, [2]=next, [3]=mode
  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_deb;
  logic [3:0]       r_press;
  logic [3:0][15:0] r_cnt;

  assign w_raw = {btn_mode, btn_next, btn_b, btn_a};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i]   <= '0;
          r_press[i] <= 1'b0;
        end else if (r_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          r_deb[i]   <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_press[i] <= r_sync2[i];
        end else begin
          r_cnt[i]   <= r_cnt[i] + 16'd1;
          r_press[i] <= 1'b0;
        end
      end
    end
  end

  logic w_next_press;
  logic w_mode_press;
  assign w_next_press = r_press[2];
  assign w_mode_press = r_press[3];

  state_t      r_state,  w_state;
  logic [3:0]  r_idx,    w_idx;
  logic [23:0] r_dwell,  w_dwell;
  logic [1:0]  r_mopt,   w_mopt;
  logic        r_op_a,   w_op_a;
  logic        r_op_b,   w_op_b;
  logic [1:0]  r_opt,    w_opt;
  logic        r_auto,   w_auto;
  logic        r_step,   w_step;
  logic        r_done,   w_done;
  logic        w_adv;

  // Terminal count and a skip press fold into one advance request
  assign w_adv = w_next_press || (r_dwell == DWELL_CYCLES - 24'd1);

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_dwell = r_dwell;
    w_mopt  = r_mopt;
    w_step  = 1'b0;
    w_done  = 1'b0;
    w_op_a  = 1'b0;
    w_op_b  = 1'b0;
    w_opt   = 2'd0;
    w_auto  = 1'b0;
    unique case (r_state)
      ST_MANUAL: begin
        if (w_mode_press) begin
          w_state = ST_AUTO_RUN;
          w_idx   = 4'd0;
          w_dwell = 24'd0;
        end else if (w_next_press) begin
          w_mopt = r_mopt + 2'd1;
        end
      end
      ST_AUTO_RUN: begin
        if (w_mode_press) begin
          w_state = ST_MANUAL;
        end else if (w_adv) begin
          if (r_idx != 4'd15) begin
            w_idx   = r_idx + 4'd1;
            w_dwell = 24'd0;
            w_step  = 1'b1;
          end else begin
            w_state = ST_AUTO_DONE;
            w_done  = 1'b1;
          end
        end else begin
          w_dwell = r_dwell + 24'd1;
        end
      end
      ST_AUTO_DONE: begin
        if (w_mode_press) begin
          w_state = ST_MANUAL;
        end else if (w_next_press) begin
          w_state = ST_AUTO_RUN;
          w_idx   = 4'd0;
          w_dwell = 24'd0;
        end
      end
      default: w_state = ST_MANUAL;
    endcase

    // Outputs are computed from the next state so they line up with the state register
    if (w_state == ST_MANUAL) begin
      w_op_a = r_deb[0];
      w_op_b = r_deb[1];
      w_opt  = w_mopt;
      w_auto = 1'b0;
    end else begin
      {w_opt, w_op_a, w_op_b} = w_idx;
      w_auto = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_MANUAL;
      r_idx   <= '0;
      r_dwell <= '0;
      r_mopt  <= '0;
      r_op_a  <= 1'b0;
      r_op_b  <= 1'b0;
      r_opt   <= '0;
      r_auto  <= 1'b0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_dwell <= w_dwell;
      r_mopt  <= w_mopt;
      r_op_a  <= w_op_a;
      r_op_b  <= w_op_b;
      r_opt   <= w_opt;
      r_auto  <= w_auto;
      r_step  <= w_step;
      r_done  <= w_done;
    end
  end

  assign operand_a   = r_op_a;
  assign operand_b   = r_op_b;
  assign option      = r_opt;
  assign auto_active = r_auto;
  assign step_strobe = r_step;
  assign sweep_done  = r_done;

endmodule

// File: tb/tb_alu_demo_sequencer.sv
// Bench for alu_demo_sequencer: per-cycle reference model, a vector table for manual mode,
// hand-timed sequences for skip/abort/collision/reset, then randomized button traffic.
module tb_alu_demo_sequencer;

  localparam int DEB   = 4;
  localparam int DWELL = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic       operand_a;
  logic       operand_b;
  logic [1:0] option;
  logic       auto_active;
  logic       step_strobe;
  logic       sweep_done;

  always #5 CLK = ~CLK;

  alu_demo_sequencer #(
    .DEBOUNCE_CYCLES(16'(DEB)),
    .DWELL_CYCLES   (24'(DWELL))
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .btn_next   (btn_next),
    .btn_mode   (btn_mode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .option     (option),
    .auto_active(auto_active),
    .step_strobe(step_strobe),
    .sweep_done (sweep_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: buttons reach the FSM two samples late; a level flips after DEB
  // consecutive disagreeing samples, and a 0->1 flip is a press seen by the next cycle.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_press = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  int         m_mode = 0;      // 0 manual, 1 sweeping, 2 sweep finished
  int         m_idx = 0, m_elapsed = 0, m_mopt = 0;
  logic       e_a = 1'b0, e_b = 1'b0, e_auto = 1'b0, e_step = 1'b0, e_done = 1'b0;
  logic [1:0] e_opt = 2'd0;

  task automatic model_update();
    logic [3:0] raw;
    raw = {btn_mode, btn_next, btn_b, btn_a};
    if (RST) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = 0; m_idx = 0; m_elapsed = 0; m_mopt = 0;
      e_a = 0; e_b = 0; e_opt = 0; e_auto = 0; e_step = 0; e_done = 0;
      return;
    end
    e_step = 0;
    e_done = 0;
    case (m_mode)
      0: begin
        if (m_press[3]) begin
          m_mode = 1; m_idx = 0; m_elapsed = 0;
        end else if (m_press[2]) begin
          m_mopt = (m_mopt + 1) % 4;
        end
      end
      1: begin
        if (m_press[3]) m_mode = 0;
        else if (m_press[2] || m_elapsed == DWELL - 1) begin
          if (m_idx < 15) begin
            m_idx = m_idx + 1; m_elapsed = 0; e_step = 1;
          end else begin
            m_mode = 2; e_done = 1;
          end
        end else m_elapsed = m_elapsed + 1;
      end
      default: begin
        if (m_press[3]) m_mode = 0;
        else if (m_press[2]) begin
          m_mode = 1; m_idx = 0; m_elapsed = 0;
        end
      end
    endcase
    if (m_mode == 0) begin
      e_a = m_deb[0]; e_b = m_deb[1]; e_opt = 2'(m_mopt); e_auto = 0;
    end else begin
      e_opt = 2'(m_idx / 4); e_a = 1'((m_idx / 2) % 2); e_b = 1'(m_idx % 2); e_auto = 1;
    end
    for (int i = 0; i < 4; i++) begin
      m_press[i] = 1'b0;
      if (m_s2[i] != m_deb[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_deb[i] = m_s2[i]; m_run[i] = 0; m_press[i] = m_s2[i];
        end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step_cyc();
    @(posedge CLK);
    model_update();
    #1;
    check("model_operand_a", 32'(operand_a), 32'(e_a));
    check("model_operand_b", 32'(operand_b), 32'(e_b));
    check("model_option", 32'(option), 32'(e_opt));
    check("model_auto_active", 32'(auto_active), 32'(e_auto));
    check("model_step_strobe", 32'(step_strobe), 32'(e_step));
    check("model_sweep_done", 32'(sweep_done), 32'(e_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cyc();
  endtask

  function automatic logic [3:0] cur_idx();
    return {option, operand_a, operand_b};
  endfunction

  task automatic wait_idx(input string name, input int target, input int limit, input bit need_strobe);
    bit found;
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      step_cyc();
      if (cur_idx() == 4'(target) && auto_active && (!need_strobe || step_strobe)) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  typedef struct {
    logic       a, b, nx, md;
    int         cyc;
    logic [1:0] opt;
    logic       ea, eb, eauto;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n_str, n_done;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 2'd1, 1'b0, 1'b0, 1'b0};

    // Reset with every button held: outputs stay 0, then the held mode press starts a sweep
    RST = 1; btn_a = 1; btn_b = 1; btn_next = 1; btn_mode = 1;
    run(2);
    check("rst_outputs", 32'({operand_a, operand_b, option, auto_active, step_strobe, sweep_done}), 32'd0);
    RST = 0;
    run(6);
    check("held_pre_auto", 32'(auto_active), 32'd0);
    run(1);
    check("held_mode_wins", 32'(auto_active), 32'd1);
    check("held_next_dropped", 32'(option), 32'd0);

    // Only operand buttons held through reset: operand appears 2+DEB+1 cycles after release
    RST = 1; btn_next = 0; btn_mode = 0;
    run(2);
    RST = 0;
    run(6);
    check("latency_early_a", 32'(operand_a), 32'd0);
    run(1);
    check("latency_a", 32'(operand_a), 32'd1);
    check("latency_b", 32'(operand_b), 32'd1);
    btn_a = 0; btn_b = 0;
    run(8);

    // Bouncing step button: nothing until it settles, then exactly one increment
    for (int k = 0; k < 10; k++) begin
      btn_next = (k % 2 == 0);
      run(2);
    end
    check("bounce_no_step", 32'(option), 32'd0);
    btn_next = 1;
    run(10);
    check("bounce_one_step", 32'(option), 32'd1);
    btn_next = 0;
    run(8);

    for (int i = 0; i < 10; i++) begin
      {btn_a, btn_b, btn_next, btn_mode} = {tbl[i].a, tbl[i].b, tbl[i].nx, tbl[i].md};
      run(tbl[i].cyc);
      check($sformatf("vec%0d_option", i), 32'(option), 32'(tbl[i].opt));
      check($sformatf("vec%0d_a", i), 32'(operand_a), 32'(tbl[i].ea));
      check($sformatf("vec%0d_b", i), 32'(operand_b), 32'(tbl[i].eb));
      check($sformatf("vec%0d_auto", i), 32'(auto_active), 32'(tbl[i].eauto));
    end

    // Full sweep: each strobe carries the next index, 15 strobes, one done pulse
    n_str = 0; n_done = 0;
    btn_mode = 1;
    for (int c = 0; c < 60; c++) begin
      if (c == 8) btn_mode = 0;
      step_cyc();
      if (step_strobe) begin
        n_str++;
        check("sweep_strobe_idx", 32'(cur_idx()), 32'(n_str));
      end
      if (sweep_done) n_done++;
    end
    check("sweep_strobes", 32'(n_str), 32'd15);
    check("sweep_done_count", 32'(n_done), 32'd1);
    run(5);
    check("done_hold_idx", 32'(cur_idx()), 32'd15);
    check("done_auto", 32'(auto_active), 32'd1);

    // Restart from AUTO_DONE, then skip at idx=5
    btn_next = 1;
    run(7);
    check("restart_idx0", 32'({auto_active, cur_idx()}), 32'h10);
    btn_next = 0;
    wait_idx("wait_idx3", 3, 30, 1);
    btn_next = 1;
    run(6);
    check("skip_pre_idx", 32'(cur_idx()), 32'd5);
    run(1);
    check("skip_idx", 32'(cur_idx()), 32'd6);
    check("skip_strobe", 32'(step_strobe), 32'd1);
    btn_next = 0;
    run(2);
    check("skip_dwell_restart", 32'(cur_idx()), 32'd6);
    run(1);
    check("skip_next_step", 32'(cur_idx()), 32'd7);

    // Mode and next together: abort to MANUAL with the saved option, next discarded
    btn_mode = 1; btn_next = 1;
    run(7);
    check("abort_auto", 32'(auto_active), 32'd0);
    check("abort_option", 32'(option), 32'd1);
    check("abort_no_strobe", 32'(step_strobe), 32'd0);
    btn_mode = 0; btn_next = 0;
    run(10);
    check("abort_next_dropped", 32'(option), 32'd1);

    // Skip press landing on the dwell terminal cycle at idx=2
    btn_mode = 1;
    run(9);
    btn_mode = 0; btn_next = 1;
    run(6);
    check("collide_pre_idx", 32'(cur_idx()), 32'd2);
    run(1);
    check("collide_idx", 32'(cur_idx()), 32'd3);
    check("collide_strobe", 32'(step_strobe), 32'd1);
    btn_next = 0;
    run(1);
    check("collide_single_strobe", 32'(step_strobe), 32'd0);
    run(1);
    check("collide_hold", 32'(cur_idx()), 32'd3);
    run(1);
    check("collide_next_idx", 32'(cur_idx()), 32'd4);

    // Reset mid-sweep
    wait_idx("wait_idx9", 9, 40, 0);
    RST = 1;
    run(1);
    check("midrst_outputs", 32'({operand_a, operand_b, option, auto_active, step_strobe, sweep_done}), 32'd0);
    RST = 0;
    run(3);
    check("midrst_manual_opt", 32'({auto_active, option}), 32'd0);

    // Random button traffic against the model
    for (int it = 0; it < 300; it++) begin
      btn_a    = 1'($urandom_range(0, 1));
      btn_b    = 1'($urandom_range(0, 1));
      btn_next = ($urandom_range(0, 3) == 0);
      btn_mode = ($urandom_range(0, 7) == 0);
      RST      = ($urandom_range(0, 60) == 0);
      run($urandom_range(1, 12));
    end
    RST = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
